chip8_sprite_drawer: RTL

- Executes CHIP-8 display instructions (DXYN sprite draw, 00E0 clear) against the 256-byte monochrome framebuffer BRAM.
- Sits upstream of the video multiplexer: writes port A of the dual-port framebuffer; the multiplexer reads port B.
- Framebuffer layout: byte address = row*8 + col/8, row 0..31, col 0..63; bit 7 of each byte is the leftmost pixel.
- Fetches sprite bytes from CHIP-8 main memory, XORs them into the framebuffer and reports collision (VF).

---
 rtl/chip8_pkg.sv | 29 ++
 rtl/chip8_sprite_drawer_if.sv | 37 +++
 rtl/chip8_sprite_drawer_pipe.sv | 25 ++
 rtl/chip8_sprite_drawer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// Shared constants, command codes and FSM state type for the CHIP-8 sprite drawer.
package chip8_pkg;

  localparam int FB_COLS          = 64;
  localparam int FB_ROWS          = 32;
  localparam int FB_BYTES_PER_ROW = 8;
  localparam int FB_DEPTH         = 256;

  localparam logic CMD_DRAW  = 1'b0;
  localparam logic CMD_CLEAR = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SPR_RD,
    ST_FB_RD_L,
    ST_WR_L,
    ST_FB_RD_R,
    ST_WR_R,
    ST_NEXT,
    ST_DONE
  } state_t;

  // Upper byte is the mask for the left framebuffer byte, lower byte spills into the right one.
  function automatic logic [15:0] split_masks(input logic [7:0] s, input logic [2:0] o);
    return {s, 8'h00} >> o;
  endfunction

endpackage

// File: rtl/chip8_sprite_drawer_if.sv
// Command, sprite-memory and framebuffer port-A signals of the sprite drawer.
interface chip8_sprite_drawer_if;
  import chip8_pkg::*;

  // Handshake: a command is taken on any rising clock edge where req_valid_in and
  // ready_out are both high; ready_out is high only while idle, so requests made
  // while busy are simply not taken. done_out pulses once per accepted command.
  logic        req_valid_in;
  logic        cmd_in;
  logic [7:0]  x_in;
  logic [7:0]  y_in;
  logic [3:0]  n_in;
  logic [11:0] i_in;
  logic        ready_out;
  logic        done_out;
  logic        collision_out;
  logic [11:0] mem_addr_out;
  logic [7:0]  mem_data_in;
  logic [7:0]  fb_addr_out;
  logic [7:0]  fb_data_in;
  logic [7:0]  fb_data_out;
  logic        fb_we_out;
  state_t      state_dbg;

  modport master (
    output req_valid_in, cmd_in, x_in, y_in, n_in, i_in, mem_data_in, fb_data_in,
    input  ready_out, done_out, collision_out, mem_addr_out,
           fb_addr_out, fb_data_out, fb_we_out, state_dbg
  );

  modport slave (
    input  req_valid_in, cmd_in, x_in, y_in, n_in, i_in, mem_data_in, fb_data_in,
    output ready_out, done_out, collision_out, mem_addr_out,
           fb_addr_out, fb_data_out, fb_we_out, state_dbg
  );

endinterface

// File: rtl/chip8_sprite_drawer_pipe.sv
// Generic reset-cleared delay line; used here to time RAM read-data-valid strobes.
module chip8_sprite_drawer_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stages [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) stages[k] <= '0;
    end else begin
      stages[0] <= d;
      for (int k = 1; k < DEPTH; k++) stages[k] <= stages[k-1];
    end
  end

  assign q = stages[DEPTH-1];

endmodule

// File: rtl/chip8_sprite_drawer.sv
// CHIP-8 DXYN / 00E0 engine: XORs sprite rows into the byte-wide framebuffer via port A.
module chip8_sprite_drawer
  import chip8_pkg::*;
#(
  parameter int RAM_LATENCY = 2
) (
  input logic                   clk_in,
  input logic                   rst_n_in,
  chip8_sprite_drawer_if.slave  bus
);

  state_t      state;
  logic [5:0]  x0;
  logic [4:0]  y0;
  logic [3:0]  n;
  logic [11:0] base;
  logic [3:0]  row;
  logic [7:0]  spr;
  logic        coll;
  logic        collision;
  logic [11:0] mem_addr;
  logic [7:0]  fb_addr;
  logic [7:0]  fb_wdata;
  logic        fb_we;
  logic        rd_go;
  logic        rd_valid;

  logic [15:0] masks;
  logic [3:0]  next_row;
  logic [4:0]  fb_row;
  logic        need_right;
  logic        more_rows;

  chip8_sprite_drawer_pipe #(.WIDTH(1), .DEPTH(RAM_LATENCY)) u_rd_pipe (
    .clk   (clk_in),
    .rst_n (rst_n_in),
    .d     (rd_go),
    .q     (rd_valid)
  );

  assign masks      = split_masks(spr, x0[2:0]);
  assign next_row   = row + 4'd1;
  assign fb_row     = y0 + {1'b0, row};
  // Right byte exists only for unaligned sprites not already in the last byte column.
  assign need_right = (x0[2:0] != 3'd0) && (x0[5:3] != 3'd7);
  assign more_rows  = (next_row < n) && (({1'b0, y0} + {2'b00, next_row}) < 6'(FB_ROWS));

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= ST_IDLE;
      x0        <= '0;
      y0        <= '0;
      n         <= '0;
      base      <= '0;
      row       <= '0;
      spr       <= '0;
      coll      <= 1'b0;
      collision <= 1'b0;
      mem_addr  <= '0;
      fb_addr   <= '0;
      fb_wdata  <= '0;
      fb_we     <= 1'b0;
      rd_go     <= 1'b0;
    end else begin
      rd_go <= 1'b0;
      case (state)
        ST_IDLE: if (bus.req_valid_in) begin
          x0        <= 6'(bus.x_in % 8'(FB_COLS));
          y0        <= 5'(bus.y_in % 8'(FB_ROWS));
          n         <= bus.n_in;
          base      <= bus.i_in;
          row       <= '0;
          coll      <= 1'b0;
          collision <= 1'b0;
          if (bus.cmd_in == CMD_CLEAR) begin
            state    <= ST_CLEAR;
            fb_addr  <= '0;
            fb_wdata <= '0;
            fb_we    <= 1'b1;
          end else if (bus.n_in == 4'd0) begin
            state <= ST_DONE;
          end else begin
            state    <= ST_SPR_RD;
            mem_addr <= bus.i_in;
            rd_go    <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (fb_addr == 8'(FB_DEPTH - 1)) begin
            fb_we <= 1'b0;
            state <= ST_DONE;
          end else begin
            fb_addr <= fb_addr + 8'd1;
          end
        end
        ST_SPR_RD: if (rd_valid) begin
          spr     <= bus.mem_data_in;
          fb_addr <= {fb_row, x0[5:3]};
          rd_go   <= 1'b1;
          state   <= ST_FB_RD_L;
        end
        ST_FB_RD_L: if (rd_valid) begin
          fb_wdata <= bus.fb_data_in ^ masks[15:8];
          fb_we    <= 1'b1;
          coll     <= coll | (|(bus.fb_data_in & masks[15:8]));
          state    <= ST_WR_L;
        end
        ST_WR_L: begin
          fb_we <= 1'b0;
          if (need_right) begin
            fb_addr <= fb_addr + 8'd1;
            rd_go   <= 1'b1;
            state   <= ST_FB_RD_R;
          end else begin
            state <= ST_NEXT;
          end
        end
        ST_FB_RD_R: if (rd_valid) begin
          fb_wdata <= bus.fb_data_in ^ masks[7:0];
          fb_we    <= 1'b1;
          coll     <= coll | (|(bus.fb_data_in & masks[7:0]));
          state    <= ST_WR_R;
        end
        ST_WR_R: begin
          fb_we <= 1'b0;
          state <= ST_NEXT;
        end
        ST_NEXT: begin
          row <= next_row;
          if (more_rows) begin
            mem_addr <= base + {8'h00, next_row};
            rd_go    <= 1'b1;
            state    <= ST_SPR_RD;
          end else begin
            collision <= coll;
            state     <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ready_out     = (state == ST_IDLE);
  assign bus.done_out      = (state == ST_DONE);
  assign bus.collision_out = collision;
  assign bus.mem_addr_out  = mem_addr;
  assign bus.fb_addr_out   = fb_addr;
  assign bus.fb_data_out   = fb_wdata;
  assign bus.fb_we_out     = fb_we;
  assign bus.state_dbg     = state;

endmodule
